// File: rtl/i2s_rx.sv
`default_nettype none
`timescale 1ns/1ps
// i2s_rx: oversampling I2S receiver that delivers complete left/right pairs in the clk domain.
// Revision 1.0
module i2s_rx #(
  parameter int DATA_BITS = 16,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_sclk,
  input  logic                 rx_lrclk,
  input  logic                 rx_sd,
  output logic [DATA_BITS-1:0] audio_l,
  output logic [DATA_BITS-1:0] audio_r,
  output logic                 rd_valid,
  output logic                 frame_err
);

  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // Bit order in the synchronizer vectors: [2] sclk, [1] lrclk, [0] sd.
  logic [2:0]           sync1_q;
  logic [2:0]           sync2_q;
  logic                 sclk_d3_q;

  logic                 w_sclk_rise;
  logic                 w_lr;
  logic                 w_sd;
  logic                 w_boundary;
  logic                 w_well_formed;
  logic [DATA_BITS-1:0] w_word;

  logic [DATA_BITS-2:0] shift_q;
  logic [DATA_BITS-2:0] shift_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [CNT_W-1:0]     bit_cnt_d;
  logic                 lr_prev_q;
  logic                 lr_prev_d;

  state_t               state_q;
  logic [DATA_BITS-1:0] left_hold_q;
  logic [DATA_BITS-1:0] audio_l_q;
  logic [DATA_BITS-1:0] audio_r_q;
  logic                 rd_valid_q;
  logic                 frame_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 3'b000;
      sync2_q   <= 3'b000;
      sclk_d3_q <= 1'b0;
    end else begin
      sync1_q   <= {rx_sclk, rx_lrclk, rx_sd};
      sync2_q   <= sync1_q;
      sclk_d3_q <= sync2_q[2];
    end
  end

  assign w_sclk_rise   = sync2_q[2] & ~sclk_d3_q;
  assign w_lr          = sync2_q[1];
  assign w_sd          = sync2_q[0];
  assign w_boundary    = w_sclk_rise & (w_lr != lr_prev_q);
  assign w_well_formed = (bit_cnt_q == C_CNT_LAST);

  // The newest bit completes the word combinationally, so only DATA_BITS-1 bits of history are stored.
  assign w_word = {shift_q, w_sd};

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    lr_prev_d = lr_prev_q;
    if (w_sclk_rise) begin
      shift_d   = w_word[DATA_BITS-2:0];
      lr_prev_d = w_lr;
      if (w_boundary) begin
        bit_cnt_d = '0;
      end else if (bit_cnt_q != C_CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      lr_prev_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      lr_prev_q <= lr_prev_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SYNC;
      left_hold_q <= '0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (w_boundary) begin
        case (state_q)
          ST_SYNC: begin
            if (!w_lr) begin
              state_q <= ST_LEFT;
            end
          end
          ST_LEFT: begin
            if (w_lr) begin
              if (w_well_formed) begin
                left_hold_q <= w_word;
                state_q     <= ST_RIGHT;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_SYNC;
              end
            end
          end
          ST_RIGHT: begin
            if (!w_lr) begin
              if (w_well_formed) begin
                audio_l_q  <= left_hold_q;
                audio_r_q  <= w_word;
                rd_valid_q <= 1'b1;
                state_q    <= ST_LEFT;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_SYNC;
              end
            end
          end
          default: state_q <= ST_SYNC;
        endcase
      end
    end
  end

  assign audio_l   = audio_l_q;
  assign audio_r   = audio_r_q;
  assign rd_valid  = rd_valid_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
`timescale 1ns/1ps
// tb_i2s_rx: drives I2S word streams and compares received pairs/errors with a word-level model.
// Revision 1.0
module tb_i2s_rx;

  localparam int DB = 16;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          rx_sclk  = 1'b0;
  logic          rx_lrclk = 1'b0;
  logic          rx_sd    = 1'b0;
  logic [DB-1:0] audio_l;
  logic [DB-1:0] audio_r;
  logic          rd_valid;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_rx #(.DATA_BITS(DB), .CNT_W(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_sclk   (rx_sclk),
    .rx_lrclk  (rx_lrclk),
    .rx_sd     (rx_sd),
    .audio_l   (audio_l),
    .audio_r   (audio_r),
    .rd_valid  (rd_valid),
    .frame_err (frame_err)
  );

  // Word-level reference: what the receiver is waiting for next.
  typedef enum int {M_HUNT, M_WANT_L, M_WANT_R} mphase_t;
  mphase_t       m_phase;
  logic [DB-1:0] m_left;
  logic [DB-1:0] m_held_l;
  logic [DB-1:0] m_held_r;
  logic [32:0]   exp_q[$];
  logic [32:0]   got_q[$];

  bit            prev_ch;
  int            prev_len;
  logic [127:0]  prev_val;
  bit            pend_sd;
  int            sclk_half = 50;
  realtime       t_bnd = 0.0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Judges the word that just ended (from_ch) when the opposite channel begins.
  function automatic void model_boundary(input bit from_ch, input int len, input logic [127:0] val);
    bit            ok;
    logic [DB-1:0] w;
    ok = (len == DB);
    w  = val[DB-1:0];
    if (from_ch == 1'b0) begin
      if (m_phase == M_WANT_L) begin
        if (ok) begin
          m_left  = w;
          m_phase = M_WANT_R;
        end else begin
          exp_q.push_back({1'b1, m_held_l, m_held_r});
          m_phase = M_HUNT;
        end
      end
    end else begin
      if (m_phase == M_HUNT) begin
        m_phase = M_WANT_L;
      end else if (m_phase == M_WANT_R) begin
        if (ok) begin
          exp_q.push_back({1'b0, m_left, w});
          m_held_l = m_left;
          m_held_r = w;
          m_phase  = M_WANT_L;
        end else begin
          exp_q.push_back({1'b1, m_held_l, m_held_r});
          m_phase = M_HUNT;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_phase  = M_HUNT;
    m_held_l = '0;
    m_held_r = '0;
    prev_len = -1;
  endfunction

  // One word of len bits on channel ch; data lags word select by one bit period.
  task automatic drive_word(input bit ch, input int len, input logic [127:0] val);
    bit bnd;
    bnd = (ch != prev_ch);
    if (bnd) model_boundary(prev_ch, prev_len, prev_val);
    for (int b = len - 1; b >= 0; b--) begin
      rx_sclk  = 1'b0;
      rx_lrclk = ch;
      rx_sd    = pend_sd;
      #(sclk_half);
      rx_sclk = 1'b1;
      if (bnd && b == len - 1) t_bnd = $realtime;
      #(sclk_half);
      pend_sd = val[b];
    end
    prev_ch  = ch;
    prev_len = len;
    prev_val = val;
  endtask

  task automatic compare_events(input string tag);
    #100;
    check({tag, " event count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, " event"}, 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, " audio_l held"}, 64'(audio_l), 64'(m_held_l));
    check({tag, " audio_r held"}, 64'(audio_r), 64'(m_held_r));
    got_q.delete();
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (reset_n && (rd_valid || frame_err)) begin
      check("pulse exclusivity", 64'(rd_valid & frame_err), 64'd0);
      check("pin-to-pulse latency", 64'(($realtime - t_bnd) <= 60.0), 64'd1);
      got_q.push_back({frame_err, audio_l, audio_r});
    end
  end

  initial begin
    logic [DB-1:0] lv;
    logic [DB-1:0] rv;
    m_phase  = M_HUNT;
    m_left   = '0;
    m_held_l = '0;
    m_held_r = '0;
    prev_ch  = 1'b0;
    prev_len = -1;
    prev_val = '0;
    pend_sd  = 1'b0;

    #37;
    check("reset audio_l", 64'(audio_l), 64'd0);
    check("reset audio_r", 64'(audio_r), 64'd0);
    check("reset rd_valid", 64'(rd_valid), 64'd0);
    check("reset frame_err", 64'(frame_err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Sync frame, then a fixed stereo pair closed by the next left word.
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, 128'h0000_AAAA);
    drive_word(1'b1, DB, 128'h0000_5555);
    drive_word(1'b0, DB, 128'h0000_AAAA);
    compare_events("stereo");
    check("stereo audio_l", 64'(audio_l), 64'h0000_AAAA);
    check("stereo audio_r", 64'(audio_r), 64'h0000_5555);

    // Ten consecutive frames: left = AAAA-i, right = AAAA+i.
    for (int i = 0; i < 10; i++) begin
      rv = 16'hAAAA + 16'(i);
      lv = 16'hAAAA - 16'(i + 1);
      drive_word(1'b1, DB, 128'(rv));
      drive_word(1'b0, DB, (i < 9) ? 128'(lv) : rnd());
    end
    compare_events("loopback");

    for (int k = 0; k < 6; k++) begin
      drive_word(1'b1, DB, rnd());
      drive_word(1'b0, DB, rnd());
    end
    compare_events("random");

    // 15-bit left word.
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB - 1, rnd());
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, rnd());
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, rnd());
    compare_events("short left");

    // 17-bit right word, then an 80-bit right word that overruns the bit counter.
    drive_word(1'b1, DB + 1, rnd());
    drive_word(1'b0, DB, rnd());
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, rnd());
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, rnd());
    compare_events("long right");

    drive_word(1'b1, 80, rnd());
    drive_word(1'b0, DB, rnd());
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, rnd());
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, rnd());
    compare_events("saturated right");

    // Reset pulsed in the middle of a left word.
    drive_word(1'b1, DB, rnd());
    fork
      drive_word(1'b0, DB, rnd());
      begin
        #(sclk_half * 2 * 6 + 3);
        reset_n = 1'b0;
        #1;
        check("async clear audio_l", 64'(audio_l), 64'd0);
        check("async clear audio_r", 64'(audio_r), 64'd0);
        check("async clear rd_valid", 64'(rd_valid), 64'd0);
        #25;
        @(negedge clk);
        reset_n = 1'b1;
      end
    join
    model_reset();
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, rnd());
    drive_word(1'b1, DB, rnd());
    drive_word(1'b0, DB, rnd());
    compare_events("mid-word reset");

    // clk/8 bit clock with its phase stepped across one clk period.
    sclk_half = 40;
    for (int ph = 0; ph < 8; ph++) begin
      #1.25;
      drive_word(1'b1, DB, 128'h0000_BEEF);
      drive_word(1'b0, DB, 128'h0000_1234);
    end
    compare_events("phase sweep");
    check("phase audio_l", 64'(audio_l), 64'h0000_1234);
    check("phase audio_r", 64'(audio_r), 64'h0000_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
